mm_port_scheduler: RTL and testbench

MM_PORT_SCHEDULER -- requirements
Module: mm_port_scheduler

---
 rtl/mm_port_scheduler.sv | 124 ++++++++++++
 tb/tb_mm_port_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_port_scheduler.sv
// Round-robin arbiter that gives N_CH channels one shared local-memory write port per job.
// Grant is combinational, so a write goes out in its request cycle; a channel that is refused simply keeps req high.
module mm_port_scheduler #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [N_CH*CNT_W-1:0]   size,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         grant,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [N_CH-1:0]         ch_done,
  output logic                    rdy,
  output logic                    done
);

  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PART_W = ADDR_W - $clog2(N_CH);
  localparam logic [ADDR_W-1:0] PART_MASK = ADDR_W'((64'd1 << PART_W) - 64'd1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       state;
  logic             start_q;
  logic             armed;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] idx;
  logic             gvld;
  logic [N_CH-1:0]  elig;
  logic             launch;
  logic             all_done;
  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] size_r [N_CH];

  // armed stays low after reset until start is seen low, so a start held high
  // through reset cannot relaunch a job on its own.
  assign launch   = start & ~start_q & armed;
  assign all_done = &ch_done;
  assign elig     = (state == S_RUN) ? (req & ~ch_done) : '0;

  always_comb begin
    grant = '0;
    gidx  = '0;
    gvld  = 1'b0;
    idx   = '0;
    for (int off = 0; off < N_CH; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N_CH);
      if (!gvld && elig[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        gvld       = 1'b1;
      end
    end
  end

  assign ptr_next = (gidx == IDX_W'(N_CH - 1)) ? '0 : gidx + 1'b1;

  // Counter bits above the partition are dropped so a long transfer wraps
  // inside its own partition instead of spilling into the next channel's.
  assign mem_en   = gvld;
  assign mem_wren = gvld;
  assign mem_addr = gvld ? ((ADDR_W'(gidx) << PART_W) | (ADDR_W'(cnt[gidx]) & PART_MASK))
                         : '0;
  assign rdy      = (state == S_RUN);
  assign done     = (state == S_FINISH);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      armed   <= 1'b0;
      ptr     <= '0;
      ch_done <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= '0;
        size_r[i] <= '0;
      end
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (launch) state <= S_LOAD;
        end
        S_LOAD: begin
          state <= S_RUN;
          for (int i = 0; i < N_CH; i++) begin
            size_r[i]  <= size[i*CNT_W +: CNT_W];
            cnt[i]     <= '0;
            ch_done[i] <= (size[i*CNT_W +: CNT_W] == '0);
          end
        end
        S_RUN: begin
          if (!start)        state <= S_IDLE;
          else if (all_done) state <= S_FINISH;
          if (gvld) ptr <= ptr_next;
          for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
              if (cnt[i] == size_r[i] - CNT_W'(1)) ch_done[i] <= 1'b1;
              else                                 cnt[i]     <= cnt[i] + CNT_W'(1);
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_port_scheduler.sv
// Directed scenarios for mm_port_scheduler; expected writes and done pulses go into a queue
// that a negedge monitor drains against the DUT outputs.
module tb_mm_port_scheduler;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 12;

  logic                  aclk;
  logic                  aresetn;
  logic                  start;
  logic [N_CH*CNT_W-1:0] size;
  logic [N_CH-1:0]       req;
  logic [N_CH-1:0]       grant;
  logic                  mem_en;
  logic                  mem_wren;
  logic [ADDR_W-1:0]     mem_addr;
  logic [N_CH-1:0]       ch_done;
  logic                  rdy;
  logic                  done;

  mm_port_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .start    (start),
    .size     (size),
    .req      (req),
    .grant    (grant),
    .mem_en   (mem_en),
    .mem_wren (mem_wren),
    .mem_addr (mem_addr),
    .ch_done  (ch_done),
    .rdy      (rdy),
    .done     (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        is_done;
    logic [3:0]  gnt;
    logic [11:0] addr;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   wr_cnt   = 0;
  int   base;
  bit   mon_en   = 1'b0;

  task automatic push_wr(input logic [3:0] g, input logic [11:0] a);
    exp_t e;
    e.is_done = 1'b0;
    e.gnt     = g;
    e.addr    = a;
    expq.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.gnt     = 4'b0000;
    e.addr    = 12'h000;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req_v);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Counts negedges from the call (first negedge = 1) until done is seen.
  task automatic wait_done(input string name, input int exp_n);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge aclk);
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: done never seen within %0d cycles", name, n);
    end else begin
      chk(name, 32'(n), 32'(exp_n));
    end
  endtask

  task automatic wait_wr(input string name, input int target);
    int n;
    n = 0;
    while (n < 200 && wr_cnt < target) begin
      @(negedge aclk);
      #1;
      n++;
    end
    if (wr_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d writes required %0d", name, wr_cnt, target);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},   32'(grant),    32'h0);
    chk({tag, "_mem_en"},  32'(mem_en),   32'h0);
    chk({tag, "_mem_wren"},32'(mem_wren), 32'h0);
    chk({tag, "_mem_addr"},32'(mem_addr), 32'h0);
    chk({tag, "_ch_done"}, 32'(ch_done),  32'h0);
    chk({tag, "_rdy"},     32'(rdy),      32'h0);
    chk({tag, "_done"},    32'(done),     32'h0);
  endtask

  always @(negedge aclk) begin
    if (mon_en) begin
      checks++;
      if (mem_en || done) begin
        if (mem_en) wr_cnt++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: mem_en=%0b done=%0b grant=%b addr=%h, required no output",
                   mem_en, done, grant, mem_addr);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.is_done) begin
            if (!done || mem_en) begin
              failures++;
              $display("FAIL done_event: done=%0b mem_en=%0b grant=%b, required done=1 mem_en=0",
                       done, mem_en, grant);
            end
          end else if (!mem_en || !mem_wren || grant !== mon_e.gnt || mem_addr !== mon_e.addr) begin
            failures++;
            $display("FAIL write: mem_en=%0b mem_wren=%0b grant=%b addr=%h done=%0b, required grant=%b addr=%h",
                     mem_en, mem_wren, grant, mem_addr, done, mon_e.gnt, mon_e.addr);
          end
        end
      end else if (grant !== 4'b0000 || mem_addr !== 12'h000 || mem_wren !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs: grant=%b addr=%h mem_wren=%0b, required all 0",
                 grant, mem_addr, mem_wren);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    start   = 1'b0;
    req     = '0;
    size    = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk_all_zero("reset");
    mon_en = 1'b1;
    tick();
    aresetn = 1'b1;
    tick();
    tick();

    // Single channel: ch3 size 3
    size = {16'd3, 16'd0, 16'd0, 16'd0};
    req  = 4'b1000;
    push_wr(4'b1000, 12'hC00);
    push_wr(4'b1000, 12'hC01);
    push_wr(4'b1000, 12'hC02);
    push_done();
    start = 1'b1;
    wait_done("t1_done_latency", 7);
    chk("t1_ch_done", 32'(ch_done), 32'hF);
    tick();
    start = 1'b0;
    req   = '0;
    tick();
    chk("t1_rdy_after", 32'(rdy), 32'h0);

    // Fairness with all sizes 2; size input changed mid-run must be ignored
    size = {16'd2, 16'd2, 16'd2, 16'd2};
    req  = 4'b1111;
    push_wr(4'b0001, 12'h000);
    push_wr(4'b0010, 12'h400);
    push_wr(4'b0100, 12'h800);
    push_wr(4'b1000, 12'hC00);
    push_wr(4'b0001, 12'h001);
    push_wr(4'b0010, 12'h401);
    push_wr(4'b0100, 12'h801);
    push_wr(4'b1000, 12'hC01);
    push_done();
    start = 1'b1;
    tick();
    tick();
    tick();
    size = {16'd7, 16'd7, 16'd7, 16'd7};
    wait_done("t2_done_latency", 9);
    chk("t2_ch_done", 32'(ch_done), 32'hF);
    tick();
    start = 1'b0;
    req   = '0;
    tick();

    // All sizes zero: requests ignored, immediate finish
    size = '0;
    req  = 4'b1111;
    push_done();
    start = 1'b1;
    wait_done("t3_done_latency", 4);
    chk("t3_ch_done", 32'(ch_done), 32'hF);
    tick();
    start = 1'b0;
    req   = '0;
    tick();

    // Gaps: ch0, then ch3 (skipping ch1/ch2), then ch1 with idle-request cycles
    size = {16'd2, 16'd0, 16'd2, 16'd2};
    req  = 4'b0001;
    push_wr(4'b0001, 12'h000);
    push_wr(4'b0001, 12'h001);
    push_wr(4'b1000, 12'hC00);
    push_wr(4'b1000, 12'hC01);
    push_wr(4'b0010, 12'h400);
    push_wr(4'b0010, 12'h401);
    push_done();
    base  = wr_cnt;
    start = 1'b1;
    wait_wr("t4_ch0_writes", base + 2);
    tick();
    req = 4'b1000;
    wait_wr("t4_ch3_writes", base + 4);
    tick();
    req = 4'b0000;
    chk("t4_rdy_gap", 32'(rdy), 32'h1);
    chk("t4_ch_done_gap", 32'(ch_done), 32'hD);
    tick();
    tick();
    tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    wait_done("t4_done_after_gap", 2);
    chk("t4_ch_done", 32'(ch_done), 32'hF);
    tick();
    start = 1'b0;
    tick();

    // Abort after 2 of 5 words on ch0, then restart from address 0
    size = {16'd0, 16'd0, 16'd0, 16'd5};
    req  = 4'b0001;
    push_wr(4'b0001, 12'h000);
    push_wr(4'b0001, 12'h001);
    base  = wr_cnt;
    start = 1'b1;
    wait_wr("t5_pre_abort", base + 2);
    start = 1'b0;
    @(negedge aclk);
    chk("t5_rdy_abort", 32'(rdy), 32'h0);
    chk("t5_done_abort", 32'(done), 32'h0);
    chk("t5_ch_done_kept", 32'(ch_done), 32'hE);
    tick();
    tick();
    tick();
    push_wr(4'b0001, 12'h000);
    push_wr(4'b0001, 12'h001);
    push_wr(4'b0001, 12'h002);
    push_wr(4'b0001, 12'h003);
    push_wr(4'b0001, 12'h004);
    push_done();
    start = 1'b1;
    wait_done("t5_restart_latency", 9);
    chk("t5_ch_done", 32'(ch_done), 32'hF);
    tick();
    start = 1'b0;
    req   = '0;
    tick();

    // Reset during RUN with start held high
    size = {16'd0, 16'd0, 16'd0, 16'd4};
    req  = 4'b0001;
    push_wr(4'b0001, 12'h000);
    base  = wr_cnt;
    start = 1'b1;
    wait_wr("t6_pre_reset", base + 1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk_all_zero("t6_reset");
    #1;
    aresetn = 1'b1;
    repeat (6) tick();
    chk("t6_no_relaunch_rdy", 32'(rdy), 32'h0);
    start = 1'b0;
    tick();
    push_wr(4'b0001, 12'h000);
    push_wr(4'b0001, 12'h001);
    push_wr(4'b0001, 12'h002);
    push_wr(4'b0001, 12'h003);
    push_done();
    start = 1'b1;
    wait_done("t6_relaunch_latency", 8);
    tick();
    start = 1'b0;
    req   = '0;
    repeat (3) tick();

    chk("scoreboard_drain", 32'(expq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
